// File: rtl/mem_load_store_pkg.sv
// Shared CPU pipeline types and helpers for the memory-access stage.
package mem_load_store_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  function automatic logic op_is_load(input mem_op_t op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic op_is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Halfword ops need an even address, word ops a 4-byte aligned one.
  function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return lo[0];
      MEM_LW, MEM_SW:          return |lo;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] op_byte_en(input mem_op_t op, input logic [1:0] lo);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 4'b0001 << lo;
      MEM_LH, MEM_LHU, MEM_SH: return lo[1] ? 4'b1100 : 4'b0011;
      MEM_LW, MEM_SW:          return 4'b1111;
      default:                 return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_store_align.sv
// Little-endian lane extraction and sign/zero extension of load data.
module mem_load_align
  import mem_load_store_pkg::*;
(
  input  mem_op_t             op,
  input  logic [1:0]          addr_lo,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W-1:0]   ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] b);
    return 32'(b);
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] h);
    return 32'(h);
  endfunction

  // Select the addressed lane and extend it according to the load type.
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEM_LB:  ext = sext8(byte_sel);
      MEM_LBU: ext = {24'h0, byte_sel};
      MEM_LH:  ext = sext16(half_sel);
      MEM_LHU: ext = {16'h0, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_store.sv
// Memory-access stage: bus request/grant/response for loads and stores,
// load alignment, and the registered MEM/WB payload.
module mem_load_store
  import mem_load_store_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_store_data,
  input  mem_op_t           ex_mem_op,
  input  logic [31:0]       ex_pc_address,
  input  logic [4:0]        ex_reg_dest,
  input  logic              ex_write_en,
  input  logic              ex_branch_link,
  output logic              mem_stall,
  output logic              data_req,
  output logic              data_we,
  output logic [31:0]       data_addr,
  output logic [3:0]        data_be,
  output logic [31:0]       data_wdata,
  input  logic              data_gnt,
  input  logic              data_rvalid,
  input  logic [31:0]       data_rdata,
  output logic [31:0]       result,
  output logic [31:0]       pc_address,
  output logic [4:0]        reg_dest,
  output logic              write_en,
  output logic              branch_link,
  output logic              addr_err,
  output logic [31:0]       bad_vaddr
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t            state_p0;
  state_t            state_nxt;
  logic              is_ld;
  logic              is_st;
  logic              is_mem;
  logic              misal;
  logic              start;
  logic [31:0]       load_ext;

  mem_load_align u_align (
    .op      (ex_mem_op),
    .addr_lo (ex_result[1:0]),
    .rdata   (data_rdata),
    .ext     (load_ext)
  );

  // Decode the held execute-stage op; a request may only start from IDLE.
  always_comb begin
    is_ld  = op_is_load(ex_mem_op);
    is_st  = op_is_store(ex_mem_op);
    is_mem = is_ld || is_st;
    misal  = is_mem && op_misaligned(ex_mem_op, ex_result[1:0]);
    start  = rst && (state_p0 == ST_IDLE) && ex_valid && is_mem && !misal;
  end

  // Bus fields are always derived from the held ex_* inputs.
  always_comb begin
    data_addr = {ex_result[31:2], 2'b00};
    data_we   = is_st;
    data_be   = op_byte_en(ex_mem_op, ex_result[1:0]);
    case (ex_mem_op)
      MEM_SB:  data_wdata = {4{ex_store_data[7:0]}};
      MEM_SH:  data_wdata = {2{ex_store_data[15:0]}};
      default: data_wdata = ex_store_data;
    endcase
  end

  // Next-state, request and stall; both forced low while reset is held.
  always_comb begin
    state_nxt = state_p0;
    data_req  = 1'b0;
    mem_stall = 1'b0;
    case (state_p0)
      ST_IDLE: begin
        if (start) begin
          data_req  = 1'b1;
          mem_stall = 1'b1;
          state_nxt = data_gnt ? ST_WAIT : ST_REQ;
        end
      end
      ST_REQ: begin
        data_req  = 1'b1;
        mem_stall = 1'b1;
        if (data_gnt) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (data_rvalid) state_nxt = ST_IDLE;
        else             mem_stall = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!rst) begin
      data_req  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_p0 <= ST_IDLE;
    else      state_p0 <= state_nxt;
  end

  // MEM/WB payload register: pass-through, load/store completion, bubble or error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result      <= '0;
      pc_address  <= '0;
      reg_dest    <= '0;
      write_en    <= 1'b0;
      branch_link <= 1'b0;
      addr_err    <= 1'b0;
      bad_vaddr   <= '0;
    end else begin
      addr_err <= 1'b0;
      if ((state_p0 == ST_IDLE) && ex_valid && misal) begin
        result      <= '0;
        pc_address  <= '0;
        reg_dest    <= '0;
        write_en    <= 1'b0;
        branch_link <= 1'b0;
        addr_err    <= 1'b1;
        bad_vaddr   <= ex_result;
      end else if ((state_p0 == ST_IDLE) && ex_valid && !is_mem) begin
        result      <= ex_result;
        pc_address  <= ex_pc_address;
        reg_dest    <= ex_reg_dest;
        write_en    <= ex_write_en;
        branch_link <= ex_branch_link;
      end else if ((state_p0 == ST_WAIT) && data_rvalid) begin
        result      <= is_ld ? load_ext : ex_result;
        pc_address  <= ex_pc_address;
        reg_dest    <= ex_reg_dest;
        write_en    <= ex_write_en && !is_st;
        branch_link <= ex_branch_link;
      end else begin
        result      <= '0;
        pc_address  <= '0;
        reg_dest    <= '0;
        write_en    <= 1'b0;
        branch_link <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_load_store.sv
// Self-checking bench for mem_load_store with a byte-level memory reference model.
module tb_mem_load_store;
  import mem_load_store_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  mem_op_t     ex_mem_op;
  logic [31:0] ex_pc_address;
  logic [4:0]  ex_reg_dest;
  logic        ex_write_en;
  logic        ex_branch_link;
  logic        mem_stall;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic [31:0] result;
  logic [31:0] pc_address;
  logic [4:0]  reg_dest;
  logic        write_en;
  logic        branch_link;
  logic        addr_err;
  logic [31:0] bad_vaddr;

  always #5 clk = ~clk;

  mem_load_store dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op),
    .ex_pc_address(ex_pc_address), .ex_reg_dest(ex_reg_dest),
    .ex_write_en(ex_write_en), .ex_branch_link(ex_branch_link),
    .mem_stall(mem_stall), .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_be(data_be), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .result(result), .pc_address(pc_address), .reg_dest(reg_dest),
    .write_en(write_en), .branch_link(branch_link), .addr_err(addr_err),
    .bad_vaddr(bad_vaddr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference memory (spec-level byte semantics) and the bus slave's memory.
  logic [7:0] ref_mem   [1024];
  logic [7:0] slave_mem [1024];

  // Observations captured by the driver for one instruction.
  int          obs_req, obs_stall, obs_bub, obs_cyc;
  bit          obs_to;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata;
  logic        obs_we;

  function automatic int op_size(input mem_op_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit is_store(input mem_op_t op);
    return op == MEM_SB || op == MEM_SH || op == MEM_SW;
  endfunction

  function automatic logic [31:0] ref_load(input mem_op_t op, input logic [31:0] a);
    logic [31:0] v = 0;
    int sz = op_size(op);
    for (int i = 0; i < sz; i++) v = v + (32'(ref_mem[int'(a[9:0]) + i]) << (8 * i));
    if (op == MEM_LB && v >= 128)   v = v - 256;
    if (op == MEM_LH && v >= 32768) v = v - 65536;
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input int sz);
    logic [3:0] be = 0;
    for (int i = 0; i < sz; i++) be[(int'(a[1:0]) + i) % 4] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int sz);
    logic [31:0] w = 0;
    for (int l = 0; l < 4; l++) w[8*l +: 8] = d[8*(l % sz) +: 8];
    return w;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input int sz);
    for (int i = 0; i < sz; i++) ref_mem[int'(a[9:0]) + i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    int o = int'(a[9:0]);
    return {slave_mem[o+3], slave_mem[o+2], slave_mem[o+1], slave_mem[o]};
  endfunction

  // Present one instruction (entered at a negedge) and play the bus slave:
  // grant after gdly request cycles, respond rdly cycles after the grant.
  task automatic run_op(input mem_op_t op, input logic [31:0] res, input logic [31:0] sdata,
                        input logic [31:0] pc, input logic [4:0] dest, input logic we,
                        input logic bl, input int gdly, input int rdly);
    int t = 0, req_t = 0, gnt_t = 0;
    bit granted = 0, done = 0;
    ex_valid = 1'b1; ex_mem_op = op; ex_result = res; ex_store_data = sdata;
    ex_pc_address = pc; ex_reg_dest = dest; ex_write_en = we; ex_branch_link = bl;
    obs_req = 0; obs_stall = 0; obs_bub = 0; obs_be = 0; obs_addr = 0; obs_wdata = 0; obs_we = 0;
    while (!done && t < 64) begin
      data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = $urandom;
      if (granted && t == gnt_t + rdly) begin
        data_rvalid = 1'b1;
        data_rdata  = slave_word(obs_addr);
      end
      #1;
      if (t > 0 && (write_en !== 1'b0 || branch_link !== 1'b0)) obs_bub++;
      if (data_req === 1'b1) begin
        obs_req++;
        if (!granted && req_t == gdly) begin
          data_gnt = 1'b1; granted = 1; gnt_t = t;
          obs_be = data_be; obs_addr = data_addr; obs_wdata = data_wdata; obs_we = data_we;
          if (data_we === 1'b1)
            for (int l = 0; l < 4; l++)
              if (data_be[l]) slave_mem[int'(data_addr[9:0]) + l] = data_wdata[8*l +: 8];
        end
        req_t++;
      end
      #1;
      if (mem_stall === 1'b1) obs_stall++;
      else done = 1;
      @(negedge clk);
      t++;
    end
    obs_to = !done;
    obs_cyc = t;
    ex_valid = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; ex_valid = 1'b1; ex_mem_op = MEM_LW; ex_result = 32'h100;
    ex_store_data = 0; ex_pc_address = 32'h8; ex_reg_dest = 1; ex_write_en = 1; ex_branch_link = 1;
    data_gnt = 0; data_rvalid = 0; data_rdata = 0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (data_req !== 1'b0) $display("FAIL reset_req got %b want 0", data_req); else n_pass++;
    n_checks++; if (mem_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", mem_stall); else n_pass++;
    n_checks++;
    if ({result, pc_address, reg_dest, write_en, branch_link, addr_err, bad_vaddr} !== 104'h0)
      $display("FAIL reset_outputs got %h/%h/%h/%b/%b/%b/%h want all 0", result, pc_address,
               reg_dest, write_en, branch_link, addr_err, bad_vaddr);
    else n_pass++;
    ex_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu;
    run_op(MEM_NONE, 32'h1234, 32'h0, 32'h40, 5'd5, 1'b1, 1'b0, 0, 1);
    n_checks++; if (result !== 32'h1234) $display("FAIL alu_result got %h want 1234", result); else n_pass++;
    n_checks++; if (reg_dest !== 5'd5 || write_en !== 1'b1)
      $display("FAIL alu_dest got %0d/%b want 5/1", reg_dest, write_en); else n_pass++;
    n_checks++; if (obs_stall !== 0 || obs_req !== 0 || obs_cyc !== 1)
      $display("FAIL alu_timing got stall=%0d req=%0d cyc=%0d want 0/0/1", obs_stall, obs_req, obs_cyc);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (write_en !== 1'b0) $display("FAIL bubble_we got %b want 0", write_en); else n_pass++;
  endtask

  task automatic test_branch_link;
    run_op(MEM_NONE, 32'h404, 32'h0, 32'h400, 5'd31, 1'b1, 1'b1, 0, 1);
    n_checks++; if (branch_link !== 1'b1 || pc_address !== 32'h400)
      $display("FAIL branch_link got %b/%h want 1/400", branch_link, pc_address); else n_pass++;
  endtask

  task automatic test_load_byte;
    for (int i = 0; i < 3; i++) begin ref_mem[32'h100 + i] = 8'hFF; slave_mem[32'h100 + i] = 8'hFF; end
    ref_mem[32'h103] = 8'h80; slave_mem[32'h103] = 8'h80;
    run_op(MEM_LB, 32'h103, 32'h0, 32'h10, 5'd4, 1'b1, 1'b0, 0, 2);
    n_checks++; if (obs_be !== 4'b1000 || obs_addr !== 32'h100 || obs_we !== 1'b0)
      $display("FAIL lb_bus got be=%b addr=%h we=%b want 1000/100/0", obs_be, obs_addr, obs_we); else n_pass++;
    n_checks++; if (obs_stall !== 2 || obs_cyc !== 3 || obs_bub !== 0)
      $display("FAIL lb_stall got stall=%0d cyc=%0d bub=%0d want 2/3/0", obs_stall, obs_cyc, obs_bub); else n_pass++;
    n_checks++; if (result !== 32'hFFFF_FF80 || write_en !== 1'b1)
      $display("FAIL lb_result got %h/%b want ffffff80/1", result, write_en); else n_pass++;
    run_op(MEM_LBU, 32'h103, 32'h0, 32'h14, 5'd4, 1'b1, 1'b0, 0, 2);
    n_checks++; if (result !== 32'h0000_0080) $display("FAIL lbu_result got %h want 00000080", result); else n_pass++;
  endtask

  task automatic test_store_half;
    run_op(MEM_SH, 32'h202, 32'h0000_ABCD, 32'h20, 5'd6, 1'b1, 1'b0, 3, 1);
    ref_store(32'h202, 32'h0000_ABCD, 2);
    n_checks++; if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD || obs_we !== 1'b1)
      $display("FAIL sh_bus got be=%b wdata=%h we=%b want 1100/abcdabcd/1", obs_be, obs_wdata, obs_we); else n_pass++;
    n_checks++; if (obs_req !== 4) $display("FAIL sh_req_cycles got %0d want 4", obs_req); else n_pass++;
    n_checks++; if (write_en !== 1'b0 || obs_cyc !== 5)
      $display("FAIL sh_writeback got we=%b cyc=%0d want 0/5", write_en, obs_cyc); else n_pass++;
  endtask

  task automatic test_misaligned;
    mem_op_t ops [3] = '{MEM_LW, MEM_SH, MEM_LHU};
    logic [31:0] adr [3] = '{32'h101, 32'h203, 32'h105};
    for (int k = 0; k < 3; k++) begin
      run_op(ops[k], adr[k], 32'h55, 32'h30, 5'd2, 1'b1, 1'b1, 0, 1);
      n_checks++; if (obs_req !== 0 || obs_stall !== 0)
        $display("FAIL misal_bus%0d got req=%0d stall=%0d want 0/0", k, obs_req, obs_stall); else n_pass++;
      n_checks++; if (addr_err !== 1'b1 || bad_vaddr !== adr[k] || write_en !== 1'b0 || branch_link !== 1'b0)
        $display("FAIL misal_report%0d got %b/%h/%b/%b want 1/%h/0/0", k, addr_err, bad_vaddr,
                 write_en, branch_link, adr[k]); else n_pass++;
      @(negedge clk);
      n_checks++; if (addr_err !== 1'b0) $display("FAIL misal_pulse%0d got %b want 0", k, addr_err); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d = $urandom;
    run_op(MEM_SW, 32'h300, d, 32'h50, 5'd8, 1'b1, 1'b0, 0, 1);
    ref_store(32'h300, d, 4);
    n_checks++; if (obs_cyc !== 2 || write_en !== 1'b0)
      $display("FAIL b2b_store got cyc=%0d we=%b want 2/0", obs_cyc, write_en); else n_pass++;
    run_op(MEM_LW, 32'h300, 32'h0, 32'h54, 5'd9, 1'b1, 1'b0, 0, 1);
    n_checks++; if (obs_cyc !== 2 || obs_req !== 1 || result !== d)
      $display("FAIL b2b_load got cyc=%0d req=%0d result=%h want 2/1/%h", obs_cyc, obs_req, result, d); else n_pass++;
    run_op(MEM_LH, 32'h302, 32'h0, 32'h58, 5'd10, 1'b1, 1'b0, 1, 1);
    n_checks++; if (result !== ref_load(MEM_LH, 32'h302))
      $display("FAIL b2b_lh got %h want %h", result, ref_load(MEM_LH, 32'h302)); else n_pass++;
  endtask

  task automatic test_random;
    for (int it = 0; it < 60; it++) begin
      mem_op_t     op   = mem_op_t'($urandom_range(0, 8));
      int          sz   = op_size(op);
      logic [31:0] a    = 32'($urandom_range(0, 1019));
      logic [31:0] sd   = $urandom;
      logic [31:0] pc   = $urandom;
      logic [4:0]  dst  = 5'($urandom);
      logic        bl   = 1'($urandom);
      int          gd   = $urandom_range(0, 3);
      int          rd   = $urandom_range(1, 3);
      bit          mis;
      logic [31:0] exp_res;
      if (sz > 1) a = a & ~32'(sz - 1);
      if (sz > 1 && $urandom_range(0, 7) == 0) a = a + 1;
      mis = sz > 1 && (a % sz) != 0;
      exp_res = (sz != 0 && !is_store(op)) ? ref_load(op, a) : a;
      run_op(op, a, sd, pc, dst, 1'b1, bl, gd, rd);
      if (mis) begin
        n_checks++; if (addr_err !== 1'b1 || bad_vaddr !== a || obs_req !== 0 || write_en !== 1'b0)
          $display("FAIL rnd_misal it=%0d got %b/%h/%0d/%b want 1/%h/0/0", it, addr_err, bad_vaddr,
                   obs_req, write_en, a); else n_pass++;
      end else if (sz == 0) begin
        n_checks++; if ({result, pc_address, reg_dest, write_en, branch_link} !== {a, pc, dst, 1'b1, bl} || obs_cyc !== 1)
          $display("FAIL rnd_alu it=%0d got %h/%h/%0d/%b/%b cyc=%0d want %h/%h/%0d/1/%b cyc=1", it, result,
                   pc_address, reg_dest, write_en, branch_link, obs_cyc, a, pc, dst, bl); else n_pass++;
      end else begin
        n_checks++; if (obs_be !== ref_be(a, sz) || obs_addr !== {a[31:2], 2'b00} || obs_we !== is_store(op) ||
                        (is_store(op) && obs_wdata !== ref_wdata(sd, sz)))
          $display("FAIL rnd_bus it=%0d op=%0d got be=%b addr=%h we=%b wd=%h want be=%b", it, op, obs_be,
                   obs_addr, obs_we, obs_wdata, ref_be(a, sz)); else n_pass++;
        n_checks++; if ({result, pc_address, reg_dest, write_en, branch_link} !== {exp_res, pc, dst, !is_store(op), bl})
          $display("FAIL rnd_payload it=%0d op=%0d got %h/%h/%0d/%b/%b want %h/%h/%0d/%b/%b", it, op, result,
                   pc_address, reg_dest, write_en, branch_link, exp_res, pc, dst, !is_store(op), bl); else n_pass++;
        n_checks++; if (obs_cyc !== gd + rd + 1 || obs_stall !== gd + rd || obs_bub !== 0 || obs_to)
          $display("FAIL rnd_timing it=%0d got cyc=%0d stall=%0d bub=%0d want %0d/%0d/0", it, obs_cyc,
                   obs_stall, obs_bub, gd + rd + 1, gd + rd); else n_pass++;
        if (is_store(op)) ref_store(a, sd, sz);
      end
      if ($urandom_range(0, 3) == 0) begin
        data_rvalid = 1'b1; data_rdata = $urandom;
        #1;
        n_checks++; if (mem_stall !== 1'b0 || data_req !== 1'b0)
          $display("FAIL stale_rvalid it=%0d got stall=%b req=%b want 0/0", it, mem_stall, data_req); else n_pass++;
        @(negedge clk);
        data_rvalid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid;
    run_op(MEM_NONE, 32'hDEAD_BEEF, 32'h0, 32'h44, 5'd7, 1'b1, 1'b1, 0, 1);
    ex_valid = 1'b1; ex_mem_op = MEM_LW; ex_result = 32'h100; ex_write_en = 1'b1; ex_branch_link = 1'b1;
    #1 data_gnt = 1'b1;
    @(negedge clk);
    data_gnt = 1'b0;
    #1;
    n_checks++; if (mem_stall !== 1'b1) $display("FAIL mid_wait_stall got %b want 1", mem_stall); else n_pass++;
    rst = 1'b0; ex_valid = 1'b0;
    #1;
    n_checks++; if ({result, pc_address, reg_dest, write_en, branch_link, mem_stall, data_req} !== 72'h0)
      $display("FAIL mid_reset_async got %h/%h/%0d/%b/%b/%b/%b want all 0", result, pc_address, reg_dest,
               write_en, branch_link, mem_stall, data_req); else n_pass++;
    @(negedge clk);
    rst = 1'b1; data_rvalid = 1'b1; data_rdata = 32'h1234_5678;
    #1;
    n_checks++; if (mem_stall !== 1'b0 || data_req !== 1'b0)
      $display("FAIL mid_stale_rvalid got stall=%b req=%b want 0/0", mem_stall, data_req); else n_pass++;
    @(negedge clk);
    data_rvalid = 1'b0;
    n_checks++; if ({result, write_en, branch_link, addr_err} !== 35'h0)
      $display("FAIL mid_outputs got %h/%b/%b/%b want 0/0/0/0", result, write_en, branch_link, addr_err); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i]   = 8'($urandom);
      slave_mem[i] = ref_mem[i];
    end
    test_reset;
    test_alu;
    test_branch_link;
    test_load_byte;
    test_store_half;
    test_misaligned;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_load_store.md
# mem_load_store

Memory-access pipeline stage that sits directly upstream of `wb_writeback`. It takes the execute-stage result and memory-op descriptor, and runs a request/grant/response transaction on the data bus for loads and stores. It aligns and extends load data, then registers the MEM/WB payload that the writeback stage consumes. It stalls the upstream pipeline while a bus transaction is outstanding.

## Interface
- No parameters; widths fixed at 32-bit data/address, 5-bit register index.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: upstream presents an instruction this cycle.
- `ex_result` in 32: ALU result; effective address for memory ops.
- `ex_store_data` in 32: rt value for stores.
- `ex_mem_op` in 4: `mem_op_t` (NONE, LB, LBU, LH, LHU, LW, SB, SH, SW).
- `ex_pc_address`, `ex_reg_dest`, `ex_write_en`, `ex_branch_link` in 32/5/1/1: pass-through payload.
- `mem_stall` out 1: upstream must hold all `ex_*` inputs while high.
- `data_req` out 1, `data_we` out 1, `data_addr` out 32, `data_be` out 4, `data_wdata` out 32: bus request.
- `data_gnt` in 1: request accepted this cycle.
- `data_rvalid` in 1, `data_rdata` in 32: response (loads and stores both receive one).
- `result`, `pc_address`, `reg_dest`, `write_en`, `branch_link` out 32/32/5/1/1: registered MEM/WB payload to writeback.
- `addr_err` out 1, `bad_vaddr` out 32: registered misalignment report.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, no valid memory op:
  - `mem_stall`=0.
  - Outputs register the pass-through payload at the next edge; `result`=`ex_result`.
  - If `ex_valid`=0, register a bubble (`write_en`=`branch_link`=0).
- IDLE, aligned memory op with `ex_valid`=1:
  - Drive `data_req`=1 combinationally and set `mem_stall`=1.
  - `data_gnt`=1 → WAIT; otherwise → REQ.
  - Output registers load a bubble.
- REQ:
  - `data_req`=1, with all bus fields recomputed from the held `ex_*` inputs.
  - `mem_stall`=1.
  - `data_gnt` → WAIT.
- WAIT:
  - `data_req`=0.
  - While `data_rvalid`=0: `mem_stall`=1, and the output registers load a bubble.
  - On `data_rvalid`=1: `mem_stall`=0 that same cycle, and the full payload registers at the edge.
    - Loads: `result` = aligned/extended `data_rdata`.
    - Stores: `write_en` forced to 0.
  - Then → IDLE.
- Bus fields:
  - `data_addr` = {addr[31:2],2'b00}.
  - `data_we`=1 for SB/SH/SW.
  - SB: `be` = 4'b0001<<addr[1:0]; `wdata` = byte replicated ×4.
  - SH: `be` = addr[1] ? 1100 : 0011; `wdata` = half replicated ×2.
  - SW: `be`=1111.
  - Loads: `be` per the same size rule.
- Load extraction is little-endian:
  - Byte lane = addr[1:0], halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Misalignment check:
  - LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0.
  - No bus request and no stall.
  - Next edge: `addr_err`=1, `bad_vaddr`=addr, `write_en`=0, `branch_link`=0.
  - `addr_err` holds for one cycle only.

## Timing
- All registered outputs reset to 0. FSM resets to IDLE. `data_req`=0 and `mem_stall`=0 during reset.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op: 1 cycle after `data_rvalid`.
  - Minimum memory-op latency is 2 cycles (gnt in cycle 0, rvalid in cycle 1).
- `data_rvalid` is never asserted in the same cycle as the `data_gnt` of the same transaction.
- `data_rvalid` seen in IDLE or REQ is ignored (stale response after reset).
- Reset asserted mid-transaction returns to IDLE immediately. The outstanding response is dropped.
- Only one outstanding transaction; back-to-back memory ops re-enter IDLE for one cycle between them.

## Structure
- `mem_op_t` enum goes in the shared CPU package, alongside the other pipeline opcode types.
- FSM state enum stays local to this module.
- Sub-module `mem_load_align`: combinational; inputs (op, addr[1:0], rdata); output 32-bit extended result.

## Test plan
- ALU op, `ex_result`=0x1234, `reg_dest`=5, `write_en`=1 → next cycle `result`=0x1234, `reg_dest`=5, `write_en`=1, no stall.
- LB, addr 0x103, `rdata`=0x80FF_FFFF:
  - gnt in cycle 0, rvalid in cycle 2.
  - Expect `data_be`=1000 and stall in cycles 0–1.
  - Cycle 3: `result`=0xFFFF_FF80.
  - Same test as LBU → 0x0000_0080.
- SH, addr 0x202, data 0xABCD, gnt delayed 3 cycles:
  - Expect `data_be`=1100, `wdata`=0xABCD_ABCD, `data_req` held for 4 cycles.
  - `write_en`=0 at output.
- LW, addr 0x101 → `addr_err`=1, `bad_vaddr`=0x101, `data_req` never asserted, `mem_stall`=0.
- `branch_link`=1, `pc_address`=0x400 → output `branch_link`=1, `pc_address`=0x400.
- Reset pulsed during WAIT, then rvalid arrives → FSM stays IDLE, outputs stay 0, no stall.
